// File: rtl/locked_grant_arbiter.sv
// rtl/locked_grant_arbiter.sv - registered fixed-priority arbiter with tenure lock, hold limit and penalty
module locked_grant_arbiter #(
   parameter int width       = 2,
   parameter int max_hold    = 16,
   parameter int cnt_width   = 5,
   parameter int owner_width = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [width-1:0]       i_request,
   input  logic                   i_release,
   output logic [width-1:0]       o_grant,
   output logic [owner_width-1:0] o_owner,
   output logic                   o_timeout
);

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } state_t;

   state_t                 state, nxt_state;
   logic [width-1:0]       r_grant, nxt_grant;
   logic [owner_width-1:0] r_owner, nxt_owner;
   logic                   r_timeout, nxt_timeout;
   logic [cnt_width-1:0]   r_cnt, nxt_cnt;
   logic [width-1:0]       r_penalty, nxt_penalty;

   logic [width-1:0]       cand;
   logic [width-1:0]       win_onehot;
   logic [owner_width-1:0] win_idx;
   logic                   win_found;
   logic                   owner_req;
   logic                   hold_done;

   // A penalised master is skipped only when someone else is asking.
   always_comb begin
      cand = i_request & ~r_penalty;
      if (cand == '0) begin
         cand = i_request;
      end
      win_onehot = '0;
      win_idx    = '0;
      win_found  = 1'b0;
      for (int i = 0; i < width; i++) begin
         if (cand[i] && !win_found) begin
            win_found     = 1'b1;
            win_onehot[i] = 1'b1;
            win_idx       = owner_width'(i);
         end
      end
   end

   always_comb begin
      owner_req = 1'b0;
      for (int i = 0; i < width; i++) begin
         if (r_owner == owner_width'(i)) begin
            owner_req = i_request[i];
         end
      end
   end

   assign hold_done = (r_cnt == cnt_width'(max_hold - 1));

   always_comb begin
      nxt_state   = state;
      nxt_grant   = r_grant;
      nxt_owner   = r_owner;
      nxt_timeout = 1'b0;
      nxt_cnt     = r_cnt;
      nxt_penalty = r_penalty;
      case (state)
         IDLE: begin
            if (win_found) begin
               nxt_state   = OWNED;
               nxt_grant   = win_onehot;
               nxt_owner   = win_idx;
               nxt_cnt     = '0;
               nxt_penalty = '0;
            end
         end
         OWNED: begin
            if (i_release || !owner_req || hold_done) begin
               nxt_state = IDLE;
               nxt_grant = '0;
               nxt_owner = '0;
               nxt_cnt   = '0;
               // Release and withdrawal both take precedence over the hold limit.
               if (!i_release && owner_req) begin
                  nxt_timeout = 1'b1;
                  nxt_penalty = r_penalty | r_grant;
               end
            end else begin
               nxt_cnt = r_cnt + cnt_width'(1);
            end
         end
         default: begin
            nxt_state = IDLE;
            nxt_grant = '0;
            nxt_owner = '0;
            nxt_cnt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         r_grant   <= '0;
         r_owner   <= '0;
         r_timeout <= 1'b0;
         r_cnt     <= '0;
         r_penalty <= '0;
      end else begin
         state     <= nxt_state;
         r_grant   <= nxt_grant;
         r_owner   <= nxt_owner;
         r_timeout <= nxt_timeout;
         r_cnt     <= nxt_cnt;
         r_penalty <= nxt_penalty;
      end
   end

   assign o_grant   = r_grant;
   assign o_owner   = r_owner;
   assign o_timeout = r_timeout;

endmodule

// File: tb/tb_locked_grant_arbiter.sv
// tb/tb_locked_grant_arbiter.sv - randomized and directed bench for locked_grant_arbiter
module tb_locked_grant_arbiter;

   localparam int W  = 4;
   localparam int MH = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] i_request;
   logic         i_release;
   logic [W-1:0] o_grant;
   logic [1:0]   o_owner;
   logic         o_timeout;

   int errors = 0;
   int checks = 0;

   // Reference: owner index (-1 = bus idle), grant cycles served so far, penalty mask, timeout flag.
   int           m_owner  = -1;
   int           m_cycles = 0;
   logic [W-1:0] m_pen    = '0;
   logic         m_to     = 1'b0;

   always #5 clk = ~clk;

   locked_grant_arbiter #(
      .width(W), .max_hold(MH), .cnt_width(3), .owner_width(2)
   ) dut (
      .clk(clk), .rst(rst), .i_request(i_request), .i_release(i_release),
      .o_grant(o_grant), .o_owner(o_owner), .o_timeout(o_timeout)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic [W-1:0] req, input logic rel, input logic r);
      logic [W-1:0] c;
      if (r) begin
         m_owner = -1; m_cycles = 0; m_pen = '0; m_to = 1'b0;
      end else if (m_owner < 0) begin
         m_to = 1'b0;
         c = req & ~m_pen;
         if (c == '0) c = req;
         for (int i = W - 1; i >= 0; i--) if (c[i]) m_owner = i;
         if (m_owner >= 0) begin
            m_cycles = 1;
            m_pen    = '0;
         end
      end else if (rel || !req[m_owner]) begin
         m_owner = -1; m_to = 1'b0;
      end else if (m_cycles == MH) begin
         m_pen[m_owner] = 1'b1;
         m_owner = -1; m_to = 1'b1;
      end else begin
         m_cycles++; m_to = 1'b0;
      end
   endtask

   task automatic step(input logic [W-1:0] req, input logic rel, input logic r);
      logic [W-1:0] eg;
      i_request = req; i_release = rel; rst = r;
      @(posedge clk);
      model_edge(req, rel, r);
      @(negedge clk);
      eg = (m_owner >= 0) ? W'(1 << m_owner) : '0;
      check_eq("grant", 32'(o_grant), 32'(eg));
      check_eq("owner", 32'(o_owner), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      check_eq("timeout", 32'(o_timeout), 32'(m_to));
   endtask

   task automatic do_reset();
      step('0, 1'b0, 1'b1);
      step('0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [W-1:0] tg [11];
      logic         tt [11];
      tg = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
             4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
      tt = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

      // reset then idle
      do_reset();
      for (int i = 0; i < 5; i++) step(4'b0000, 1'b0, 1'b0);

      // priority, latency, release in the 2nd grant cycle, regrant
      step(4'b1010, 1'b0, 1'b0);
      step(4'b1010, 1'b0, 1'b0);
      step(4'b1010, 1'b1, 1'b0);
      step(4'b1010, 1'b0, 1'b0);
      check_eq("regrant_m1", 32'(o_grant), 32'h2);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);

      // no preemption by a higher-priority master
      do_reset();
      step(4'b0100, 1'b0, 1'b0);
      step(4'b0101, 1'b0, 1'b0);
      step(4'b0101, 1'b0, 1'b0);
      check_eq("hold_m2", 32'(o_grant), 32'h4);
      step(4'b0001, 1'b0, 1'b0);
      check_eq("turnaround", 32'(o_grant), 32'h0);
      step(4'b0001, 1'b0, 1'b0);
      check_eq("then_m0", 32'(o_grant), 32'h1);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);

      // timeout and penalty against a fixed expected sequence
      do_reset();
      for (int i = 0; i < 11; i++) begin
         step(4'b0011, 1'b0, 1'b0);
         check_eq("to_seq_grant", 32'(o_grant), 32'(tg[i]));
         check_eq("to_seq_pulse", 32'(o_timeout), 32'(tt[i]));
      end

      // lone penalised master keeps winning every 5 cycles
      do_reset();
      for (int i = 0; i < 11; i++) begin
         step(4'b0100, 1'b0, 1'b0);
         check_eq("lone_grant", 32'(o_grant), (i % 5 == 4) ? 32'h0 : 32'h4);
      end

      // release coincident with the hold limit
      do_reset();
      for (int i = 0; i < 4; i++) step(4'b0001, 1'b0, 1'b0);
      step(4'b0001, 1'b1, 1'b0);
      check_eq("rel_vs_to", 32'(o_timeout), 32'h0);

      // reset during grant cycle 2
      do_reset();
      step(4'b0001, 1'b0, 1'b0);
      step(4'b0001, 1'b0, 1'b0);
      step(4'b0001, 1'b0, 1'b1);
      check_eq("rst_mid_grant", 32'(o_grant), 32'h0);
      check_eq("rst_mid_to", 32'(o_timeout), 32'h0);

      // random traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         step(W'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 63) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
